// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle CPU control FSM (INIT/IF/ID/EXE/MEM/WB)
// Optional memory handshake stall in IF/MEM when MC_CTRL_STALL_EN is defined.
module mc_ctrl_fsm #(
    parameter int ALUC_W  = 4,
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
`ifdef MC_CTRL_STALL_EN
    input  logic               mem_ready,
`endif
    output logic               pc_wen,
    output logic               ir_wen,
    output logic               mem_wen,
    output logic               reg_wen,
    output logic               sel_iord,
    output logic               sel_regdst,
    output logic               sel_memtoreg,
    output logic               sel_alusrca,
    output logic [1:0]         sel_alusrcb,
    output logic [1:0]         sel_pcsrc,
    output logic [ALUC_W-1:0]  aluc,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_INIT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(4);

    state_t cur, nxt;
    logic   ready;
    logic   is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_legal;
    logic [ALUC_W-1:0] r_aluc;

    // Without the handshake, memory is treated as always ready so IF/MEM take one cycle.
`ifdef MC_CTRL_STALL_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    assign is_r     = (op == OP_R);
    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_beq   = (op == OP_BEQ);
    assign is_addi  = (op == OP_ADDI);
    assign is_j     = (op == OP_J);
    assign is_legal = is_r | is_lw | is_sw | is_beq | is_addi | is_j;

    always_comb begin
        r_aluc = ALU_ADD;
        case (funct)
            6'b100010: r_aluc = ALU_SUB;
            6'b100100: r_aluc = ALU_AND;
            6'b100101: r_aluc = ALU_OR;
            6'b101010: r_aluc = ALU_SLT;
            default:   r_aluc = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= S_INIT;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt          = S_INIT;
        pc_wen       = 1'b0;
        ir_wen       = 1'b0;
        mem_wen      = 1'b0;
        reg_wen      = 1'b0;
        sel_iord     = 1'b0;
        sel_regdst   = 1'b0;
        sel_memtoreg = 1'b0;
        sel_alusrca  = 1'b0;
        sel_alusrcb  = 2'b00;
        sel_pcsrc    = 2'b00;
        aluc         = ALU_ADD;
        illegal      = 1'b0;
        case (cur)
            S_INIT: nxt = S_IF;
            S_IF: begin
                pc_wen      = ready;
                ir_wen      = ready;
                sel_alusrcb = 2'b01;
                nxt         = ready ? S_ID : S_IF;
            end
            S_ID: begin
                // Branch target is precomputed here so EXE only needs the compare.
                sel_alusrcb = 2'b11;
                if (is_j) begin
                    pc_wen    = 1'b1;
                    sel_pcsrc = 2'b10;
                    nxt       = S_IF;
                end else if (!is_legal) begin
                    illegal = 1'b1;
                    nxt     = S_IF;
                end else begin
                    nxt = S_EXE;
                end
            end
            S_EXE: begin
                sel_alusrca = 1'b1;
                if (is_r) begin
                    aluc = r_aluc;
                    nxt  = S_WB;
                end else if (is_beq) begin
                    aluc      = ALU_SUB;
                    sel_pcsrc = 2'b01;
                    pc_wen    = zero;
                    nxt       = S_IF;
                end else if (is_lw || is_sw) begin
                    sel_alusrcb = 2'b10;
                    nxt         = S_MEM;
                end else if (is_addi) begin
                    sel_alusrcb = 2'b10;
                    nxt         = S_WB;
                end else begin
                    nxt = S_IF;
                end
            end
            S_MEM: begin
                sel_iord = 1'b1;
                mem_wen  = is_sw;
                if (!ready) begin
                    nxt = S_MEM;
                end else if (is_lw) begin
                    nxt = S_WB;
                end else begin
                    nxt = S_IF;
                end
            end
            S_WB: begin
                reg_wen      = 1'b1;
                sel_regdst   = is_r;
                sel_memtoreg = is_lw;
                nxt          = S_IF;
            end
            default: nxt = S_INIT;
        endcase
    end

    assign state = STATE_W'(cur);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - table-driven self-checking bench for mc_ctrl_fsm
// Stall vectors are included when MC_CTRL_STALL_EN is defined.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MC_CTRL_STALL_EN
    logic       mem_ready;
`endif
    logic       pc_wen, ir_wen, mem_wen, reg_wen;
    logic       sel_iord, sel_regdst, sel_memtoreg, sel_alusrca;
    logic [1:0] sel_alusrcb, sel_pcsrc;
    logic [3:0] aluc;
    logic       illegal;
    logic [2:0] state;

    int n_cmp = 0;
    int n_fail = 0;

    mc_ctrl_fsm #(.ALUC_W(4), .STATE_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .op           (op),
        .funct        (funct),
        .zero         (zero),
`ifdef MC_CTRL_STALL_EN
        .mem_ready    (mem_ready),
`endif
        .pc_wen       (pc_wen),
        .ir_wen       (ir_wen),
        .mem_wen      (mem_wen),
        .reg_wen      (reg_wen),
        .sel_iord     (sel_iord),
        .sel_regdst   (sel_regdst),
        .sel_memtoreg (sel_memtoreg),
        .sel_alusrca  (sel_alusrca),
        .sel_alusrcb  (sel_alusrcb),
        .sel_pcsrc    (sel_pcsrc),
        .aluc         (aluc),
        .illegal      (illegal),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [2:0]  st;
        logic [16:0] ctl;
    } vec_t;

    vec_t tbl[$];

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    // {pc,ir,mem,reg,iord,regdst,memtoreg,alusrca,alusrcb,pcsrc,aluc,illegal}
    function automatic logic [16:0] mk(input logic pc, input logic ir, input logic mw,
                                       input logic rw, input logic iord, input logic rd,
                                       input logic m2r, input logic a, input logic [1:0] b,
                                       input logic [1:0] ps, input logic [3:0] alu,
                                       input logic ill);
        return {pc, ir, mw, rw, iord, rd, m2r, a, b, ps, alu, ill};
    endfunction

    function automatic logic [16:0] ctl_now();
        return {pc_wen, ir_wen, mem_wen, reg_wen, sel_iord, sel_regdst, sel_memtoreg,
                sel_alusrca, sel_alusrcb, sel_pcsrc, aluc, illegal};
    endfunction

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic r, input logic [2:0] s, input logic [16:0] c);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.st = s; v.ctl = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", nm, act, exp);
        end
    endtask

    task automatic step(input int idx);
        op    = tbl[idx].op;
        funct = tbl[idx].funct;
        zero  = tbl[idx].zero;
`ifdef MC_CTRL_STALL_EN
        mem_ready = tbl[idx].rdy;
`endif
        #1;
        chk($sformatf("row%0d state", idx), {14'b0, state}, {14'b0, tbl[idx].st});
        chk($sformatf("row%0d ctl", idx), ctl_now(), tbl[idx].ctl);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] c_zero, c_if, c_id, c_ea;
        int first;
        c_zero = '0;
        c_if   = mk(1,1,0,0,0,0,0,0,2'b01,2'b00,4'd0,0);
        c_id   = mk(0,0,0,0,0,0,0,0,2'b11,2'b00,4'd0,0);
        c_ea   = mk(0,0,0,0,0,0,0,1,2'b10,2'b00,4'd0,0);

        // R add from reset, then other functs
        add(R, 6'b100000, 0, 1, 3'd7, c_zero);
        add(R, 6'b100000, 0, 1, 3'd0, c_if);
        add(R, 6'b100000, 0, 1, 3'd1, c_id);
        add(R, 6'b100000, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'd0,0));
        add(R, 6'b100000, 0, 1, 3'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,4'd0,0));
        add(R, 6'b100010, 0, 1, 3'd0, c_if);
        add(R, 6'b100010, 0, 1, 3'd1, c_id);
        add(R, 6'b100010, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'd1,0));
        add(R, 6'b100010, 0, 1, 3'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,4'd0,0));
        add(R, 6'b101010, 0, 1, 3'd0, c_if);
        add(R, 6'b101010, 0, 1, 3'd1, c_id);
        add(R, 6'b101010, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'd4,0));
        add(R, 6'b101010, 0, 1, 3'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,4'd0,0));
        add(R, 6'b100101, 0, 1, 3'd0, c_if);
        add(R, 6'b100101, 0, 1, 3'd1, c_id);
        add(R, 6'b100101, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'd3,0));
        add(R, 6'b100101, 0, 1, 3'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,4'd0,0));
        add(R, 6'b000111, 0, 1, 3'd0, c_if);
        add(R, 6'b000111, 0, 1, 3'd1, c_id);
        add(R, 6'b000111, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b00,4'd0,0));
        add(R, 6'b000111, 0, 1, 3'd4, mk(0,0,0,1,0,1,0,0,2'b00,2'b00,4'd0,0));
        // lw
        add(LW, 6'b0, 0, 1, 3'd0, c_if);
        add(LW, 6'b0, 0, 1, 3'd1, c_id);
        add(LW, 6'b0, 0, 1, 3'd2, c_ea);
        add(LW, 6'b0, 0, 1, 3'd3, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        add(LW, 6'b0, 0, 1, 3'd4, mk(0,0,0,1,0,0,1,0,2'b00,2'b00,4'd0,0));
        // sw
        add(SW, 6'b0, 0, 1, 3'd0, c_if);
        add(SW, 6'b0, 0, 1, 3'd1, c_id);
        add(SW, 6'b0, 0, 1, 3'd2, c_ea);
        add(SW, 6'b0, 0, 1, 3'd3, mk(0,0,1,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        // addi
        add(ADDI, 6'b0, 0, 1, 3'd0, c_if);
        add(ADDI, 6'b0, 0, 1, 3'd1, c_id);
        add(ADDI, 6'b0, 0, 1, 3'd2, c_ea);
        add(ADDI, 6'b0, 0, 1, 3'd4, mk(0,0,0,1,0,0,0,0,2'b00,2'b00,4'd0,0));
        // beq taken / not taken
        add(BEQ, 6'b0, 1, 1, 3'd0, c_if);
        add(BEQ, 6'b0, 1, 1, 3'd1, c_id);
        add(BEQ, 6'b0, 1, 1, 3'd2, mk(1,0,0,0,0,0,0,1,2'b00,2'b01,4'd1,0));
        add(BEQ, 6'b0, 0, 1, 3'd0, c_if);
        add(BEQ, 6'b0, 0, 1, 3'd1, c_id);
        add(BEQ, 6'b0, 0, 1, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,2'b01,4'd1,0));
        // j, undefined op
        add(J, 6'b0, 0, 1, 3'd0, c_if);
        add(J, 6'b0, 0, 1, 3'd1, mk(1,0,0,0,0,0,0,0,2'b11,2'b10,4'd0,0));
        add(BAD, 6'b0, 0, 1, 3'd0, c_if);
        add(BAD, 6'b0, 0, 1, 3'd1, mk(0,0,0,0,0,0,0,0,2'b11,2'b00,4'd0,1));
        add(LW, 6'b0, 0, 1, 3'd0, c_if);
        add(LW, 6'b0, 0, 1, 3'd1, c_id);
        add(LW, 6'b0, 0, 1, 3'd2, c_ea);
        add(LW, 6'b0, 0, 1, 3'd3, mk(0,0,0,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        first = tbl.size();

        rst_n = 1'b0;
        op = R; funct = 6'b100000; zero = 1'b0;
`ifdef MC_CTRL_STALL_EN
        mem_ready = 1'b1;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset state", {14'b0, state}, 17'd7);
        chk("reset ctl", ctl_now(), c_zero);
        rst_n = 1'b1;
        for (int i = 0; i < first; i++) step(i);

        // reset asserted during WB of lw
        op = LW;
        #1;
        chk("lw wb state", {14'b0, state}, 17'd4);
        chk("lw wb reg_wen", {16'b0, reg_wen}, 17'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid reset state", {14'b0, state}, 17'd7);
        chk("mid reset ctl", ctl_now(), c_zero);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post reset init", {14'b0, state}, 17'd7);
        @(negedge clk);

        first = tbl.size();
`ifdef MC_CTRL_STALL_EN
        add(SW, 6'b0, 0, 0, 3'd0, mk(0,0,0,0,0,0,0,0,2'b01,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 0, 3'd0, mk(0,0,0,0,0,0,0,0,2'b01,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 0, 3'd0, mk(0,0,0,0,0,0,0,0,2'b01,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 1, 3'd0, c_if);
        add(SW, 6'b0, 0, 1, 3'd1, c_id);
        add(SW, 6'b0, 0, 1, 3'd2, c_ea);
        add(SW, 6'b0, 0, 0, 3'd3, mk(0,0,1,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 0, 3'd3, mk(0,0,1,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 1, 3'd3, mk(0,0,1,0,1,0,0,0,2'b00,2'b00,4'd0,0));
        add(SW, 6'b0, 0, 1, 3'd0, c_if);
`else
        add(R, 6'b100000, 0, 1, 3'd0, c_if);
        add(R, 6'b100000, 0, 1, 3'd1, c_id);
`endif
        for (int i = first; i < tbl.size(); i++) step(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
